// File: rtl/io_uart.sv
// UART peripheral on the CPU I/O strobe group: 8N1 TX behind a FIFO, 8N1 RX with
// a one-byte holding register, programmable baud divisor. Register map decoded from UART_A.
module io_uart #(
  parameter int unsigned TXF_LOG2  = 3,
  parameter int unsigned DIV_RESET = 434
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        UART_WE,
  input  logic        UART_RE,
  input  logic [2:0]  UART_A,
  input  logic [31:0] UART_WD,
  output logic [31:0] UART_RD,
  output logic        TXD,
  input  logic        RXD
);

  localparam int unsigned TXF_DEPTH = 1 << TXF_LOG2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        w_wr_data, w_wr_div, w_wr_ctrl, w_rd_pop;
  logic        w_unused_wd;
  logic [15:0] r_div;

  assign w_wr_data   = UART_WE && (UART_A == 3'd0);
  assign w_wr_div    = UART_WE && (UART_A == 3'd2);
  assign w_wr_ctrl   = UART_WE && (UART_A == 3'd3);
  assign w_rd_pop    = UART_RE && (UART_A == 3'd0);
  assign w_unused_wd = &{UART_WD[31:16], 1'b0};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div <= 16'(DIV_RESET);
    end else if (w_wr_div) begin
      r_div <= (UART_WD[15:1] == 15'd0) ? 16'd2 : UART_WD[15:0];
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]          r_fifo [TXF_DEPTH];
  logic [TXF_LOG2-1:0] r_wptr, r_rptr;
  logic [TXF_LOG2:0]   r_count;
  logic                w_full, w_empty, w_push, w_pop;
  logic [7:0]          w_fifo_head;

  assign w_full      = (r_count == (TXF_LOG2+1)'(TXF_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = w_wr_data && !w_full;
  assign w_fifo_head = r_fifo[r_rptr];

  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wptr] <= UART_WD[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t   r_tx_state, w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_idx;
  logic        w_tx_tick, w_txd, w_tx_empty;

  assign w_tx_tick  = (r_tx_cnt == '0);
  assign w_tx_empty = w_empty && (r_tx_state == TX_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) r_tx_state <= TX_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  // STOP expiry with a queued byte goes straight to START, leaving no idle cycle.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (!w_empty) w_tx_next = TX_START;
      TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && (r_tx_idx == 3'd7)) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_tick) w_tx_next = w_empty ? TX_IDLE : TX_START;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_txd = 1'b1;
    w_pop = 1'b0;
    case (r_tx_state)
      TX_IDLE:  w_pop = !w_empty;
      TX_START: w_txd = 1'b0;
      TX_DATA:  w_txd = r_tx_shift[0];
      TX_STOP:  w_pop = w_tx_tick && !w_empty;
      default:  w_txd = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_pop) begin
            r_tx_shift <= w_fifo_head;
            r_tx_cnt   <= r_div - 16'd1;
          end
        end
        TX_START: begin
          if (w_tx_tick) begin
            r_tx_cnt <= r_div - 16'd1;
            r_tx_idx <= '0;
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        TX_DATA: begin
          if (w_tx_tick) begin
            r_tx_cnt   <= r_div - 16'd1;
            r_tx_idx   <= r_tx_idx + 3'd1;
            r_tx_shift <= r_tx_shift >> 1;
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        default: begin
          if (w_tx_tick) begin
            if (w_pop) r_tx_shift <= w_fifo_head;
            r_tx_cnt <= r_div - 16'd1;
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
      endcase
    end
  end

  assign TXD = w_txd;

  // ---------------- RX ----------------
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t   r_rx_state, w_rx_next;
  logic [15:0] r_rx_cnt;
  logic [7:0]  r_rx_shift, r_rx_byte;
  logic [2:0]  r_rx_idx;
  logic        r_rx_valid, r_rx_overrun, r_rx_ferr;
  logic        w_rx_tick, w_rx_fall, w_rx_done_ok, w_rx_done_bad;

  assign w_rx_tick = (r_rx_cnt == '0);
  assign w_rx_fall = r_rx_prev && !r_rx_s2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_s1    <= RXD;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_idx == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_done_ok  = 1'b0;
    w_rx_done_bad = 1'b0;
    if (r_rx_state == RX_STOP && w_rx_tick) begin
      w_rx_done_ok  = r_rx_s2;
      w_rx_done_bad = !r_rx_s2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_cnt   <= '0;
      r_rx_shift <= '0;
      r_rx_idx   <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: if (w_rx_fall) r_rx_cnt <= {1'b0, r_div[15:1]} - 16'd1;
        RX_START: begin
          if (w_rx_tick) begin
            r_rx_cnt <= r_div - 16'd1;
            r_rx_idx <= '0;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= r_div - 16'd1;
            r_rx_idx   <= r_rx_idx + 3'd1;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        default: if (!w_rx_tick) r_rx_cnt <= r_rx_cnt - 16'd1;
      endcase
    end
  end

  // A pop in the completion cycle frees the holding register for the new byte.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rx_byte    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_ferr    <= 1'b0;
    end else begin
      if (w_rx_done_ok && (!r_rx_valid || w_rd_pop)) begin
        r_rx_byte  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_pop) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done_ok && r_rx_valid && !w_rd_pop) r_rx_overrun <= 1'b1;
      else if (w_wr_ctrl && UART_WD[0])            r_rx_overrun <= 1'b0;
      if (w_rx_done_bad)                           r_rx_ferr <= 1'b1;
      else if (w_wr_ctrl && UART_WD[1])            r_rx_ferr <= 1'b0;
    end
  end

  always_comb begin
    UART_RD = '0;
    case (UART_A)
      3'd0:    UART_RD = {24'd0, r_rx_byte};
      3'd1:    UART_RD = {27'd0, r_rx_ferr, r_rx_overrun, r_rx_valid, w_tx_empty, w_full};
      3'd2:    UART_RD = {16'd0, r_div};
      default: UART_RD = '0;
    endcase
  end

endmodule
